wgt_gamma_core: RTL and testbench
=================================

// Module: wgt_gamma_core
// PURPOSE
//  Weight-generation core for the TRNG post-processing path. Combines three functions:
//   - a GF(2^5) constant multiplier (y = GAMMA * x);
//   - two 5-input Boolean weight functions, WGT1 and WGT2, each a 32-entry 1-bit LUT.
//  Combinational results drive the *_o ports. The same results are also captured into
//  enable-gated output registers for the downstream pipeline.
// PARAMETERS
//  GAMMA     5'd12         field constant multiplied into gamma_x (binary 01100)
//  POLY      6'b111011     GF(2^5) reduction polynomial x^5+x^4+x^3+x+1
//  WGT1_LUT  32'hE8D46A35  WGT1 truth table; bit i = output for address i
//  WGT2_LUT  32'h1B7C93AD  WGT2 truth table; bit i = output for address i
// PORTS
//  clk        in   1  single clock; all registers update on the rising edge
//  rst        in   1  synchronous, active-high reset
//  en         in   1  capture enable for the output registers
//  gamma_x    in   5  multiplier operand
//  gamma_y    out  5  combinational GAMMA*gamma_x in GF(2^5)
//  wgt1_addr  in   5  WGT1 LUT address
//  wgt1_5o    out  1  combinational WGT1_LUT[wgt1_addr]
//  wgt2_addr  in   5  WGT2 LUT address
//  wgt2_5o    out  1  combinational WGT2_LUT[wgt2_addr]
//  gamma_y_q  out  5  registered gamma_y
//  wgt1_q     out  1  registered wgt1_5o
//  wgt2_q     out  1  registered wgt2_5o
// BEHAVIOUR
//  - Combinational outputs gamma_y, wgt1_5o and wgt2_5o have no clock or reset
//    dependence. They settle within one delta after any input change and are valid
//    even while rst=1.
//  - gamma_y is the carry-less product of gamma_x and GAMMA, reduced modulo POLY to 5 bits:
//    - form partial products (gamma_x << i) for every set bit i of GAMMA and XOR them
//      into a 9-bit value;
//    - for bit k = 8 down to 5, if set, XOR in (POLY << (k-5));
//    - gamma_y = low 5 bits.
//  - The multiplier is linear over GF(2): gamma_x=0 gives 0, and
//    f(a^b) = f(a)^f(b) for all a, b.
//  - WGT LUTs are pure bit-selects: wgt1_5o = WGT1_LUT[wgt1_addr] and
//    wgt2_5o = WGT2_LUT[wgt2_addr]. Address 0 selects the LSB and address 31 the MSB.
//    All 32 addresses are valid; there is no out-of-range case.
//  - Registers, priority order at the rising clk edge:
//    - rst=1: gamma_y_q=0, wgt1_q=0, wgt2_q=0;
//    - else en=1: capture the current gamma_y, wgt1_5o and wgt2_5o (latency 1 cycle);
//    - else en=0: hold.
//  - rst and en asserted together: reset wins.
//  - rst asserted mid-stream clears the registers at the next edge. Outputs stay 0 until
//    the first edge with rst=0 and en=1.
//  - No handshake, no state machine, no back-pressure. Register inputs are sampled only
//    at the edge; glitches between edges have no effect.
// TESTING
//  1. gamma_x = 1 -> 12 (01100); 2 -> 24 (11000); 21 (10101) -> 16 (10000);
//     4 -> 11 (01011); 0 -> 0. Check each 1 time unit after the change.
//  2. Exhaustive linearity: for all a, b in 0..31, gamma_y(a^b) == gamma_y(a)^gamma_y(b).
//     Also check no two nonzero inputs map to the same output.
//  3. WGT1: addr 0 -> 1; addr 1 -> 0; addr 2 -> 1; addr 31 -> 1.
//     WGT2: addr 0 -> 1; addr 1 -> 0; addr 2 -> 1; addr 31 -> 0.
//     Sweep all 32 addresses of each LUT against its parameter.
//  4. Hold rst=1 for 2 cycles with en=1 and gamma_x=1 -> all *_q outputs 0.
//     Release rst -> after the next edge gamma_y_q=12.
//  5. With en=1, gamma_x=2 and wgt1_addr=0, clock once, then set en=0 and gamma_x=21.
//     -> gamma_y_q stays 24 and wgt1_q stays 1 while gamma_y shows 16 immediately.
//  6. Assert rst together with en=1 mid-run -> registers read 0 after that edge.
//     The combinational outputs remain correct throughout.

Source files
------------

// File: rtl/wgt_gamma_core.sv
// Weight-generation core: GF(2^5) constant multiplier plus two 5-input LUT
// weight functions, with enable-gated output registers.
module wgt_gamma_core #(
    parameter logic [4:0]  GAMMA    = 5'd12,
    parameter logic [5:0]  POLY     = 6'b111011,
    parameter logic [31:0] WGT1_LUT = 32'hE8D46A35,
    parameter logic [31:0] WGT2_LUT = 32'h1B7C93AD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] gamma_x,
    output logic [4:0] gamma_y,
    input  logic [4:0] wgt1_addr,
    output logic       wgt1_5o,
    input  logic [4:0] wgt2_addr,
    output logic       wgt2_5o,
    output logic [4:0] gamma_y_q,
    output logic       wgt1_q,
    output logic       wgt2_q
);

    logic [8:0] prod;
    logic [4:0] gamma_y_d;
    logic       wgt1_d;
    logic       wgt2_d;

    // Carry-less product, then fold bits 8..5 back with the reduction polynomial.
    always_comb begin
        prod = '0;
        for (int i = 0; i < 5; i++) begin
            if (GAMMA[i]) prod = prod ^ ({4'b0, gamma_x} << i);
        end
        for (int k = 8; k >= 5; k--) begin
            if (prod[k]) prod = prod ^ ({3'b0, POLY} << (k - 5));
        end
        gamma_y = prod[4:0];
    end

    assign wgt1_5o = WGT1_LUT[wgt1_addr];
    assign wgt2_5o = WGT2_LUT[wgt2_addr];

    always_comb begin
        gamma_y_d = gamma_y_q;
        wgt1_d    = wgt1_q;
        wgt2_d    = wgt2_q;
        if (en) begin
            gamma_y_d = gamma_y;
            wgt1_d    = wgt1_5o;
            wgt2_d    = wgt2_5o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gamma_y_q <= '0;
            wgt1_q    <= 1'b0;
            wgt2_q    <= 1'b0;
        end else begin
            gamma_y_q <= gamma_y_d;
            wgt1_q    <= wgt1_d;
            wgt2_q    <= wgt2_d;
        end
    end

endmodule

// File: tb/tb_wgt_gamma_core.sv
// Bench for wgt_gamma_core: reference model with a scoreboard queue for the
// registered outputs and direct checks on the combinational outputs.
module tb_wgt_gamma_core;

    localparam logic [31:0] L1 = 32'hE8D46A35;
    localparam logic [31:0] L2 = 32'h1B7C93AD;

    typedef struct {
        int g;
        int w1;
        int w2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [4:0] gamma_x = '0;
    logic [4:0] gamma_y;
    logic [4:0] wgt1_addr = '0;
    logic       wgt1_5o;
    logic [4:0] wgt2_addr = '0;
    logic       wgt2_5o;
    logic [4:0] gamma_y_q;
    logic       wgt1_q;
    logic       wgt2_q;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t mstate;
    bit   seen[32];

    wgt_gamma_core dut (
        .clk(clk), .rst(rst), .en(en),
        .gamma_x(gamma_x), .gamma_y(gamma_y),
        .wgt1_addr(wgt1_addr), .wgt1_5o(wgt1_5o),
        .wgt2_addr(wgt2_addr), .wgt2_5o(wgt2_5o),
        .gamma_y_q(gamma_y_q), .wgt1_q(wgt1_q), .wgt2_q(wgt2_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Field multiply as repeated doubling: 12*x = 4x + 8x.
    function automatic int xtime(input int a);
        int r;
        r = a << 1;
        if (r & 32) r = r ^ 59;
        return r;
    endfunction

    function automatic int gmul(input int x);
        int x4, x8;
        x4 = xtime(xtime(x));
        x8 = xtime(x4);
        return x4 ^ x8;
    endfunction

    function automatic int lut(input logic [31:0] t, input int a);
        return int'((t >> a) & 32'd1);
    endfunction

    task automatic check_comb(input string tag);
        chk({tag, " gamma_y"}, int'(gamma_y), gmul(int'(gamma_x)));
        chk({tag, " wgt1_5o"}, int'(wgt1_5o), lut(L1, int'(wgt1_addr)));
        chk({tag, " wgt2_5o"}, int'(wgt2_5o), lut(L2, int'(wgt2_addr)));
    endtask

    // One clock cycle: drive at negedge, check comb, push expected register state.
    task automatic cycle(input bit r, input bit e, input int x,
                         input int a1, input int a2);
        @(negedge clk);
        rst = r;
        en = e;
        gamma_x = 5'(x);
        wgt1_addr = 5'(a1);
        wgt2_addr = 5'(a2);
        #1;
        check_comb("cyc");
        if (r) begin
            mstate = '{0, 0, 0};
        end else if (e) begin
            mstate = '{gmul(x), lut(L1, a1), lut(L2, a2)};
        end
        sb_q.push_back(mstate);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("gamma_y_q", int'(gamma_y_q), e.g);
                chk("wgt1_q", int'(wgt1_q), e.w1);
                chk("wgt2_q", int'(wgt2_q), e.w2);
            end
        end
    end

    initial begin : stim
        int xs[5];
        int ys[5];
        int cnt;
        xs = '{1, 2, 21, 4, 0};
        ys = '{12, 24, 16, 11, 0};
        mstate = '{0, 0, 0};

        // Known products from the field table.
        for (int i = 0; i < 5; i++) begin
            gamma_x = 5'(xs[i]);
            #1;
            chk("gamma_known", int'(gamma_y), ys[i]);
        end

        // Linearity over every pair, and injectivity on nonzero inputs.
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                gamma_x = 5'(a ^ b);
                #1;
                chk("linear", int'(gamma_y), gmul(a) ^ gmul(b));
            end
        end
        for (int a = 1; a < 32; a++) begin
            gamma_x = 5'(a);
            #1;
            chk("inject", int'(seen[gamma_y] || gamma_y == 0), 0);
            seen[gamma_y] = 1'b1;
        end

        // LUT corners and full sweeps.
        wgt1_addr = 5'd0; wgt2_addr = 5'd0; #1;
        chk("wgt1@0", int'(wgt1_5o), 1); chk("wgt2@0", int'(wgt2_5o), 1);
        wgt1_addr = 5'd1; wgt2_addr = 5'd1; #1;
        chk("wgt1@1", int'(wgt1_5o), 0); chk("wgt2@1", int'(wgt2_5o), 0);
        wgt1_addr = 5'd2; wgt2_addr = 5'd2; #1;
        chk("wgt1@2", int'(wgt1_5o), 1); chk("wgt2@2", int'(wgt2_5o), 1);
        wgt1_addr = 5'd31; wgt2_addr = 5'd31; #1;
        chk("wgt1@31", int'(wgt1_5o), 1); chk("wgt2@31", int'(wgt2_5o), 0);
        for (int a = 0; a < 32; a++) begin
            wgt1_addr = 5'(a);
            wgt2_addr = 5'(31 - a);
            #1;
            chk("wgt1_sweep", int'(wgt1_5o), lut(L1, a));
            chk("wgt2_sweep", int'(wgt2_5o), lut(L2, 31 - a));
        end

        // Reset held two cycles with en=1, then release.
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        @(posedge clk); #2;
        chk("post_rst_gq", int'(gamma_y_q), 12);

        // Hold while en=0; comb path follows new input.
        cycle(0, 1, 2, 0, 5);
        cycle(0, 0, 21, 1, 1);
        chk("hold_comb", int'(gamma_y), 16);
        @(posedge clk); #2;
        chk("hold_gq", int'(gamma_y_q), 24);
        chk("hold_w1q", int'(wgt1_q), 1);

        // Reset together with en mid-run.
        cycle(0, 1, 7, 31, 2);
        cycle(1, 1, 9, 31, 2);
        cycle(0, 0, 3, 4, 4);
        cycle(0, 1, 3, 4, 4);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(0, 15) == 0, 1'($urandom),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)));
        end

        cnt = 0;
        while (sb_q.size() != 0 && cnt < 10) begin
            @(posedge clk);
            cnt++;
        end
        #2;
        chk("drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
